cmos_halfbridge_driver: RTL and testbench
=========================================

Name: cmos_halfbridge_driver

Overview:
Clocked gate-drive controller for a complementary output stage: a PMOS high-side device (gate active-low) and an NMOS low-side device (gate active-high).
- Turns a requested output level into break-before-make gate signals with a programmable dead time, so both devices are never on together.
- Sits between digital control logic and the mosfet_channel_p / mosfet_channel_n switch models.

Parameters:
DEAD_CYCLES, 4, both-off cycles inserted on every turn-on; a value of 0 is treated as 1
CNT_W, 8, width of the dead-time counter; DEAD_CYCLES must be < 2**CNT_W
SW_W, 16, width of the switch-event counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  driver enable; 0 forces both devices off
in_level  input  1  requested output: 1 = pull high (PMOS on), 0 = pull low (NMOS on)
pmos_gate  output  1  high-side gate; 0 = PMOS conducting
nmos_gate  output  1  low-side gate; 1 = NMOS conducting
state  output  3  current FSM state encoding
busy  output  1  1 while in a dead-time state
sw_count  output  SW_W  number of completed device turn-ons, wraps modulo 2**SW_W

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=OFF, pmos_gate=1, nmos_gate=0, busy=0, counters=0.
- States: OFF, DEAD_H, HIGH, DEAD_L, LOW.
- Gate values per state:
  - OFF, DEAD_H, DEAD_L: pmos_gate=1, nmos_gate=0.
  - HIGH: pmos_gate=0, nmos_gate=0.
  - LOW: pmos_gate=1, nmos_gate=1.
- Invariant, checked every cycle: never (pmos_gate==0 && nmos_gate==1).
- en=0 sampled in any state -> OFF at that edge. The conducting device is released at that edge; the dead counter is cleared.
- OFF, en=1: in_level=1 -> DEAD_H; in_level=0 -> DEAD_L. The dead counter loads max(DEAD_CYCLES,1)-1.
- HIGH, en=1, in_level=0 -> DEAD_L. PMOS is released at the same edge; the counter loads.
- LOW, en=1, in_level=1 -> DEAD_H. NMOS is released at the same edge; the counter loads.
- HIGH or LOW with a matching request: hold.
- DEAD_H behaviour:
  - Counter decrements each edge.
  - At the edge where counter==0 and in_level=1: -> HIGH, pmos_gate=0, sw_count+1.
  - If in_level=0 is sampled in DEAD_H: -> DEAD_L, counter reloads. Dead time restarts; both devices stay off.
- DEAD_L: mirror of DEAD_H. Turn-on goes to LOW with nmos_gate=1; a reversed request goes to DEAD_H with reload.
- Timing:
  - Both-off interval is exactly max(DEAD_CYCLES,1) cycles after a request is sampled.
  - Turn-on latency from the sampling edge is max(DEAD_CYCLES,1) edges.
  - Turn-off latency is 0 edges (same edge).
- busy=1 exactly in DEAD_H/DEAD_L.
- sw_count wraps from 2**SW_W-1 to 0 with no flag.
- Reset asserted mid dead-time or mid-conduction: outputs go to the OFF values immediately, without waiting for a clock.

Decomposition:
- Shared package/include:
  - state encodings: OFF=0, DEAD_H=1, HIGH=2, DEAD_L=3, LOW=4
  - gate-level constants: PMOS_ON=0, PMOS_OFF=1, NMOS_ON=1, NMOS_OFF=0
- One natural sub-module: dead_time_counter, a loadable down-counter with a zero flag, async reset.
- Bench: instantiate mosfet_channel_p and mosfet_channel_n on the outputs and check the output node.

Test Plan:
1. Reset and hold: assert reset with en=0 -> pmos_gate=1, nmos_gate=0, state=OFF, sw_count=0 for all cycles.
2. Cold start high: en=1, in_level=1 from OFF, DEAD_CYCLES=4 -> busy=1 for 4 cycles, then pmos_gate=0, sw_count=1.
3. High to low: in steady HIGH, drop in_level -> pmos_gate=1 at the sampling edge, 4 cycles both off, then nmos_gate=1, sw_count=2.
4. Reversal in dead time: in DEAD_L after 2 cycles, raise in_level -> DEAD_H with counter reloaded; 4 further both-off cycles, then pmos_gate=0; no overlap.
5. Enable drop: in LOW, deassert en -> nmos_gate=0 at that edge, state=OFF. Also assert reset mid-DEAD_H -> immediate OFF values.
6. Wrap and stress: SW_W=2, toggle in_level 5 times -> sw_count sequence 1,2,3,0,1. Run 1000 random en/in_level cycles -> the invariant never violated.

Source files
------------

// File: rtl/cmos_halfbridge_driver_pkg.sv
// Shared encodings for the half-bridge gate driver: FSM states, gate levels
// and the dead-time reload helper.
package cmos_halfbridge_driver_pkg;

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_DEAD_H = 3'd1;
  localparam logic [2:0] ST_HIGH   = 3'd2;
  localparam logic [2:0] ST_DEAD_L = 3'd3;
  localparam logic [2:0] ST_LOW    = 3'd4;

  localparam logic PMOS_ON  = 1'b0;
  localparam logic PMOS_OFF = 1'b1;
  localparam logic NMOS_ON  = 1'b1;
  localparam logic NMOS_OFF = 1'b0;

  // A zero dead time would allow shoot-through, so it is clamped to one cycle.
  function automatic int dead_load(input int cycles);
    return (cycles < 1) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/cmos_halfbridge_driver_dead_time_counter.sv
// Loadable down-counter with zero flag used to time the both-off interval.
module dead_time_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mosfet_channel.sv
// Behavioural switch models for the output stage: report whether each
// device conducts for a given gate level.
module mosfet_channel_p
  import cmos_halfbridge_driver_pkg::*;
(
  input  logic gate,
  output logic conducting
);
  assign conducting = (gate == PMOS_ON);
endmodule

module mosfet_channel_n
  import cmos_halfbridge_driver_pkg::*;
(
  input  logic gate,
  output logic conducting
);
  assign conducting = (gate == NMOS_ON);
endmodule

// File: rtl/cmos_halfbridge_driver.sv
// Break-before-make gate controller for a PMOS high-side / NMOS low-side pair.
// state   | meaning
// OFF     | both devices off, waiting for enable
// DEAD_H  | both off, timing dead band before PMOS turn-on
// HIGH    | PMOS conducting
// DEAD_L  | both off, timing dead band before NMOS turn-on
// LOW     | NMOS conducting
module cmos_halfbridge_driver
  import cmos_halfbridge_driver_pkg::*;
#(
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_W       = 8,
  parameter int SW_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            in_level,
  output logic            pmos_gate,
  output logic            nmos_gate,
  output logic [2:0]      state,
  output logic            busy,
  output logic [SW_W-1:0] sw_count
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(dead_load(DEAD_CYCLES));

  logic [2:0] state_nxt;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_clr;
  logic       cnt_zero;
  logic       turn_on;

  dead_time_counter #(.CNT_W(CNT_W)) u_dead (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;
    turn_on   = 1'b0;
    if (!en) begin
      state_nxt = ST_OFF;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = in_level ? ST_DEAD_H : ST_DEAD_L;
          cnt_load  = 1'b1;
        end
        ST_DEAD_H: begin
          if (!in_level) begin
            state_nxt = ST_DEAD_L;
            cnt_load  = 1'b1;
          end else if (cnt_zero) begin
            state_nxt = ST_HIGH;
            turn_on   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_HIGH: begin
          if (!in_level) begin
            state_nxt = ST_DEAD_L;
            cnt_load  = 1'b1;
          end
        end
        ST_DEAD_L: begin
          if (in_level) begin
            state_nxt = ST_DEAD_H;
            cnt_load  = 1'b1;
          end else if (cnt_zero) begin
            state_nxt = ST_LOW;
            turn_on   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_LOW: begin
          if (in_level) begin
            state_nxt = ST_DEAD_H;
            cnt_load  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  // Gates are registered from the next state so turn-off lands on the sampling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_OFF;
      pmos_gate <= PMOS_OFF;
      nmos_gate <= NMOS_OFF;
      busy      <= 1'b0;
      sw_count  <= '0;
    end else begin
      state     <= state_nxt;
      pmos_gate <= (state_nxt == ST_HIGH) ? PMOS_ON : PMOS_OFF;
      nmos_gate <= (state_nxt == ST_LOW) ? NMOS_ON : NMOS_OFF;
      busy      <= (state_nxt == ST_DEAD_H) || (state_nxt == ST_DEAD_L);
      sw_count  <= sw_count + {{(SW_W-1){1'b0}}, turn_on};
    end
  end

endmodule

// File: tb/tb_cmos_halfbridge_driver.sv
// Directed bench for the half-bridge driver with switch models on the outputs.
module tb_cmos_halfbridge_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_level;
  logic        pmos_gate, nmos_gate, busy;
  logic [2:0]  state;
  logic [15:0] sw_count;
  logic        pmos_gate2, nmos_gate2, busy2;
  logic [2:0]  state2;
  logic [1:0]  sw_count2;
  logic        p_on, n_on;
  logic [1:0]  node;

  int checks = 0;
  int errors = 0;
  int exp_sw = 0;

  localparam logic [2:0] S_OFF = 3'd0, S_DH = 3'd1, S_HI = 3'd2, S_DL = 3'd3, S_LO = 3'd4;
  localparam logic [1:0] N_FLOAT = 2'b00, N_LOW = 2'b01, N_HIGH = 2'b10;

  always #5 clk = ~clk;

  cmos_halfbridge_driver #(.DEAD_CYCLES(4), .CNT_W(8), .SW_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .in_level(in_level),
    .pmos_gate(pmos_gate), .nmos_gate(nmos_gate), .state(state),
    .busy(busy), .sw_count(sw_count)
  );

  cmos_halfbridge_driver #(.DEAD_CYCLES(4), .CNT_W(8), .SW_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .en(en), .in_level(in_level),
    .pmos_gate(pmos_gate2), .nmos_gate(nmos_gate2), .state(state2),
    .busy(busy2), .sw_count(sw_count2)
  );

  mosfet_channel_p u_p (.gate(pmos_gate), .conducting(p_on));
  mosfet_channel_n u_n (.gate(nmos_gate), .conducting(n_on));
  assign node = {p_on, n_on};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic pg,
                         input logic ng, input logic bz, input logic [1:0] nd);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_pmos"}, 32'(pmos_gate), 32'(pg));
    chk({tag, "_nmos"}, 32'(nmos_gate), 32'(ng));
    chk({tag, "_busy"}, 32'(busy), 32'(bz));
    chk({tag, "_node"}, 32'(node), 32'(nd));
    chk({tag, "_sw"}, 32'(sw_count), 32'(exp_sw[15:0]));
    chk({tag, "_sw2"}, 32'(sw_count2), 32'(exp_sw[1:0]));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; in_level = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_all("reset_hold", S_OFF, 1'b1, 1'b0, 1'b0, N_FLOAT);
    end
    @(negedge clk); reset = 1'b0;

    // Cold start high: four both-off cycles, then PMOS on.
    en = 1'b1; in_level = 1'b1;
    tick(1);
    chk_all("cold_dead0", S_DH, 1'b1, 1'b0, 1'b1, N_FLOAT);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_all("cold_dead", S_DH, 1'b1, 1'b0, 1'b1, N_FLOAT);
    end
    tick(1); exp_sw = 1;
    chk_all("cold_high", S_HI, 1'b0, 1'b0, 1'b0, N_HIGH);
    tick(2);
    chk_all("high_hold", S_HI, 1'b0, 1'b0, 1'b0, N_HIGH);

    // High to low: PMOS released at the sampling edge.
    in_level = 1'b0;
    tick(1);
    chk_all("hl_release", S_DL, 1'b1, 1'b0, 1'b1, N_FLOAT);
    tick(3);
    chk_all("hl_dead", S_DL, 1'b1, 1'b0, 1'b1, N_FLOAT);
    tick(1); exp_sw = 2;
    chk_all("hl_low", S_LO, 1'b1, 1'b1, 1'b0, N_LOW);

    in_level = 1'b1;
    tick(4);
    chk_all("lh_dead", S_DH, 1'b1, 1'b0, 1'b1, N_FLOAT);
    tick(1); exp_sw = 3;
    chk_all("lh_high", S_HI, 1'b0, 1'b0, 1'b0, N_HIGH);

    // Reversal two cycles into DEAD_L restarts the full dead time.
    in_level = 1'b0;
    tick(3);
    chk_all("rev_in_dl", S_DL, 1'b1, 1'b0, 1'b1, N_FLOAT);
    in_level = 1'b1;
    tick(1);
    chk_all("rev_dh", S_DH, 1'b1, 1'b0, 1'b1, N_FLOAT);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_all("rev_dead", S_DH, 1'b1, 1'b0, 1'b1, N_FLOAT);
    end
    tick(1); exp_sw = 4;
    chk_all("rev_high", S_HI, 1'b0, 1'b0, 1'b0, N_HIGH);

    in_level = 1'b0;
    tick(5); exp_sw = 5;
    chk_all("wrap_low", S_LO, 1'b1, 1'b1, 1'b0, N_LOW);

    // Enable drop releases NMOS on the sampling edge.
    en = 1'b0;
    tick(1);
    chk_all("en_drop", S_OFF, 1'b1, 1'b0, 1'b0, N_FLOAT);
    tick(2);
    chk_all("en_off_hold", S_OFF, 1'b1, 1'b0, 1'b0, N_FLOAT);

    // Asynchronous reset in the middle of DEAD_H.
    en = 1'b1; in_level = 1'b1;
    tick(2);
    chk_all("pre_rst_dh", S_DH, 1'b1, 1'b0, 1'b1, N_FLOAT);
    #2 reset = 1'b1; exp_sw = 0;
    #1;
    chk_all("async_rst", S_OFF, 1'b1, 1'b0, 1'b0, N_FLOAT);
    @(negedge clk); reset = 1'b0; en = 1'b0;
    tick(1);
    chk_all("post_rst", S_OFF, 1'b1, 1'b0, 1'b0, N_FLOAT);

    // Random en/in_level: shoot-through must never occur.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 3) != 0);
      in_level = 1'($urandom_range(0, 1));
      tick(1);
      chk("no_overlap", 32'(pmos_gate == 1'b0 && nmos_gate == 1'b1), 32'd0);
      chk("no_overlap_w2", 32'(pmos_gate2 == 1'b0 && nmos_gate2 == 1'b1), 32'd0);
      chk("busy_state", 32'(busy), 32'(state == S_DH || state == S_DL));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
